matrix_mult_driver: RTL
=======================

Name: matrix_mult_driver

Overview:
Host-side driver for the 2x2 8-bit matrix multiplier stream interface.
- Holds two 2x2 operand matrices loaded by the host.
- On command, issues the 8 operand byte pairs to the multiplier with a start pulse.
- Collects the four 17-bit result elements returned on the strobed output into a readable result buffer.
- Sits between the control/register logic and the multiplier core.

Parameters:
DW, 8, operand element width
RW, 17, result element width (2*DW+1; holds the sum of two full-scale products)
TIMEOUT, 64, max cycles in WAIT between result strobes before abort

Ports:
clk  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
ld_en  in  1  host write strobe for the operand matrix
ld_sel  in  1  0 = matrix A, 1 = matrix B
ld_addr  in  2  element index {row,col}
ld_data  in  DW  element value, unsigned
go  in  1  start one multiplication (single-cycle pulse)
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
timeout_err  out  1  last operation aborted on timeout
res_addr  in  2  result index {row,col}
res_data  out  RW  result element at res_addr (combinational read)
mm_start  out  1  to multiplier: first pair valid
mm_A  out  DW  to multiplier: A operand byte
mm_B  out  DW  to multiplier: B operand byte
mm_out  in  RW  from multiplier: result element
mm_out_strobe  in  1  from multiplier: mm_out valid

Behaviour:
- Reset (async, RST=1): state IDLE; matrices, results and counters cleared. busy=0, done=0, timeout_err=0, mm_start=0, mm_A=0, mm_B=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - ld_en writes ld_data into A or B at ld_addr.
  - go moves to ISSUE and clears timeout_err, the result counter and the result buffer.
  - ld_en and go in the same cycle: the load lands first, so the new value is issued.
- ISSUE: step counter s = 0..7, one pair per cycle, outputs registered.
  - Element e = s[2:1], with i = e[1] and j = e[0]; k = s[0].
  - mm_A = A[i][k], mm_B = B[k][j].
  - mm_start=1 only at s=0.
  - Pair 0 appears the cycle after go is sampled.
  - After s=7, go to WAIT.
  - Outside ISSUE: mm_start=0, mm_A=0, mm_B=0.
- Result capture, in ISSUE and WAIT:
  - Each mm_out_strobe writes mm_out into res[cnt], then cnt++.
  - Order is C00, C01, C10, C11.
  - Strobes in IDLE/DONE, and any beyond the fourth, are ignored.
- WAIT:
  - cnt==4 (including a 4th strobe that arrived during ISSUE) -> DONE.
  - Idle counter resets on entry and on each strobe. Reaching TIMEOUT -> timeout_err=1, then DONE. Partial results are kept.
- DONE: one cycle. done=1, busy=0, then IDLE.
- busy=1 in ISSUE and WAIT only.
- go while busy is ignored; ld_en while busy is ignored (operands stay stable during issue).
- timeout_err is sticky until the next accepted go or RST.
- res_data is readable at any time and reflects captured values as they arrive.
- Reset mid-operation: immediate return to the reset state; all outputs low in the cycle RST is asserted.

Test Plan:
- Basic multiply:
  - Load A=[[1,2],[3,4]], B=[[5,6],[7,8]], go.
  - Issue sequence is (1,5),(2,7),(1,6),(2,8),(3,5),(4,7),(3,6),(4,8), with mm_start only on the first pair.
  - Model returns 19,22,43,50 -> res[0..3]=19,22,43,50; done pulses once; timeout_err=0.
- Full scale:
  - All elements 255; model returns 130050 four times.
  - res_data=0x1FC02 for each index; no truncation.
- Timeout:
  - Model returns only 2 strobes (19,22).
  - timeout_err=1 and done pulse TIMEOUT cycles after the 2nd strobe; res[0..1]=19,22, res[2..3]=0.
  - Next go clears the error.
- Early strobes:
  - Model returns all 4 strobes during ISSUE (s=4..7).
  - DONE is entered the cycle after s=7; results correct.
- Busy protection:
  - go and ld_en (A[0]=99) at s=3.
  - Issue continues unchanged; A[0] stays 1; exactly one done.
- Reset mid-issue:
  - RST at s=5 -> mm_start/mm_A/mm_B/busy=0 immediately; results cleared.
  - A later load+go works normally.

Source files
------------

// File: rtl/matrix_mult_driver.sv
// ----------------------------------------------------------------------------
// matrix_mult_driver
//
// Host-side driver for a 2x2 unsigned matrix multiplier stream core. The host
// loads two 2x2 operand matrices, then pulses go. The driver streams the eight
// operand byte pairs to the multiplier, one per cycle, marking the first pair
// with mm_start. It then gathers the four result elements returned on
// mm_out_strobe into a result buffer that the host can read at any time.
//
// Ports:
//   clk            clock, rising edge
//   RST            asynchronous reset, active-high
//   ld_en          host write strobe for an operand element
//   ld_sel         0 = matrix A, 1 = matrix B
//   ld_addr        element index {row,col}
//   ld_data        element value, unsigned
//   go             start one multiplication (single-cycle pulse)
//   busy           operation in progress (issuing or waiting for results)
//   done           one-cycle completion pulse
//   timeout_err    last operation gave up waiting for results (sticky)
//   res_addr       result index {row,col}
//   res_data       result element at res_addr (combinational read)
//   mm_start       to multiplier: first operand pair valid
//   mm_A, mm_B     to multiplier: operand bytes
//   mm_out         from multiplier: result element
//   mm_out_strobe  from multiplier: mm_out valid
// ----------------------------------------------------------------------------
module matrix_mult_driver #(
   parameter int DW      = 8,
   parameter int RW      = 17,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          RST,
   input  logic          ld_en,
   input  logic          ld_sel,
   input  logic [1:0]    ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          go,
   output logic          busy,
   output logic          done,
   output logic          timeout_err,
   input  logic [1:0]    res_addr,
   output logic [RW-1:0] res_data,
   output logic          mm_start,
   output logic [DW-1:0] mm_A,
   output logic [DW-1:0] mm_B,
   input  logic [RW-1:0] mm_out,
   input  logic          mm_out_strobe
);

   // Wide enough to hold TIMEOUT-1, the last idle count before giving up.
   localparam int IW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        state;
   logic [2:0]    step;
   logic [2:0]    step_nxt;
   logic [2:0]    cnt;
   logic [2:0]    cnt_next;
   logic [IW-1:0] idle_cnt;
   logic          strobe_take;

   logic [DW-1:0] mat_a [4];
   logic [DW-1:0] mat_b [4];
   logic [DW-1:0] a_fwd [4];
   logic [DW-1:0] b_fwd [4];
   logic [RW-1:0] res   [4];

   // Step s issues element e = s[2:1] (i = s[2], j = s[1]) with k = s[0]:
   // A is read at {i,k} and B at {k,j}.
   function automatic logic [1:0] a_idx(input logic [2:0] s);
      return {s[2], s[0]};
   endfunction

   function automatic logic [1:0] b_idx(input logic [2:0] s);
      return {s[0], s[1]};
   endfunction

   assign res_data = res[res_addr];
   assign step_nxt = step + 3'd1;

   // Result strobes only count while an operation is active and the buffer
   // still has room; extras are dropped.
   always_comb begin
      strobe_take = mm_out_strobe && (state == S_ISSUE || state == S_WAIT) &&
                    (cnt < 3'd4);
      cnt_next    = cnt + {2'b00, strobe_take};
   end

   // Operand matrices as they will be after this cycle's host write. The
   // first pair is registered on the same edge that samples go, so a write
   // arriving together with go has to be forwarded to be issued.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         a_fwd[n] = mat_a[n];
         b_fwd[n] = mat_b[n];
         if (ld_en && (ld_addr == 2'(n))) begin
            if (ld_sel) b_fwd[n] = ld_data;
            else        a_fwd[n] = ld_data;
         end
      end
   end

   // Control FSM with registered outputs, operand storage and result capture.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state       <= S_IDLE;
         step        <= '0;
         cnt         <= '0;
         idle_cnt    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         mm_start    <= 1'b0;
         mm_A        <= '0;
         mm_B        <= '0;
         for (int n = 0; n < 4; n++) begin
            mat_a[n] <= '0;
            mat_b[n] <= '0;
            res[n]   <= '0;
         end
      end else begin
         done     <= 1'b0;
         mm_start <= 1'b0;
         mm_A     <= '0;
         mm_B     <= '0;

         if (strobe_take) begin
            res[cnt[1:0]] <= mm_out;
            cnt           <= cnt_next;
         end

         case (state)
            S_IDLE: begin
               for (int n = 0; n < 4; n++) begin
                  mat_a[n] <= a_fwd[n];
                  mat_b[n] <= b_fwd[n];
               end
               if (go) begin
                  state       <= S_ISSUE;
                  step        <= 3'd0;
                  cnt         <= 3'd0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  mm_start    <= 1'b1;
                  mm_A        <= a_fwd[a_idx(3'd0)];
                  mm_B        <= b_fwd[b_idx(3'd0)];
                  for (int n = 0; n < 4; n++) res[n] <= '0;
               end
            end

            S_ISSUE: begin
               if (step == 3'd7) begin
                  // All four results may already be in from early strobes.
                  if (cnt_next == 3'd4) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state    <= S_WAIT;
                     idle_cnt <= '0;
                  end
               end else begin
                  step <= step_nxt;
                  mm_A <= mat_a[a_idx(step_nxt)];
                  mm_B <= mat_b[b_idx(step_nxt)];
               end
            end

            S_WAIT: begin
               if (cnt_next == 3'd4) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (strobe_take) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                  // Give up; whatever results arrived stay in the buffer.
                  timeout_err <= 1'b1;
                  state       <= S_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + IW'(1);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
